jtframe_dwnld_map: RTL and testbench
====================================

# jtframe_dwnld_map

Parametrised ROM-download mapper between the HPS ioctl byte stream and the SDRAM programming port. It skips a file header, splits the stream into up to 8 address regions with independent SDRAM destination offsets, and buffers bytes in a small FIFO. It also holds each 16-bit masked write until the SDRAM controller accepts it, and reports end-of-download only after every byte has been committed. It replaces the direct ioctl-to-prog wiring in the framework top level.

## Interface
Parameters:
- AW, 22: ioctl byte-address width; prog_addr is AW-1 bits wide (word address).
- HEADER, 0: number of leading bytes discarded.
- REGIONS, 1: number of regions, 1..8.
- START, 0: packed REGIONS*AW vector; START[i] is the first post-header byte of region i. START[0] must be 0 and the values must be ascending.
- OFFSET, 0: packed REGIONS*AW vector; OFFSET[i] is the SDRAM byte destination of region i. Each value must be even.
- DEPTH, 4: FIFO entries, power of 2, at least 2.

Ports:
- clk_sys  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- downloading  in  1  download window from hps_io.
- ioctl_addr  in  AW  byte address.
- ioctl_data  in  8  byte data.
- ioctl_wr  in  1  byte strobe; one cycle per byte; cannot be back-pressured.
- prog_addr  out  AW-1  SDRAM word address.
- prog_data  out  16  byte replicated on both lanes.
- prog_mask  out  2  active-low lane enable.
- prog_we  out  1  write request; held until accepted.
- prog_rdy  in  1  SDRAM acceptance; sampled only while prog_we is high.
- region  out  3  region of the current prog write.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.
- dwnld_busy  out  1  high from the downloading rise until done.
- dwnld_done  out  1  one-cycle pulse when all bytes have been committed.

## Operation
- Reset value of every output is 0. Reset also empties the FIFO and forces state IDLE.
- States:
  - IDLE→LOAD on the downloading rise. This clears overflow and sets dwnld_busy.
  - LOAD→FLUSH on the downloading fall.
  - FLUSH→IDLE when the FIFO is empty and prog_we is 0. The same edge pulses dwnld_done and clears dwnld_busy.
  - FLUSH→LOAD on a downloading rise. The FIFO is kept, no done pulse is issued, and overflow is cleared.
- Byte accept:
  - A byte is pushed when ioctl_wr & downloading & (ioctl_addr >= HEADER).
  - Header bytes, and strobes outside the download window, are ignored.
  - A push while the FIFO is full drops the byte and sets overflow. The FIFO contents are unaffected.
- Mapping, computed at pop time:
  - a = ioctl_addr - HEADER.
  - r = the highest i with a >= START[i].
  - b = OFFSET[r] + (a - START[r]), all arithmetic mod 2^AW.
  - prog_addr = b[AW-1:1]; region = r.
- Lane assignment:
  - b[0]=0 gives prog_mask=2'b10 (low lane written).
  - b[0]=1 gives prog_mask=2'b01 (high lane written).
  - prog_data = {ioctl_data, ioctl_data}.
- Output handshake:
  - When prog_we=0, or when prog_we&prog_rdy, and the FIFO is non-empty: pop, register the new address, data, mask and region, and set prog_we=1.
  - When prog_we&prog_rdy and the FIFO is empty: prog_we=0.
  - While prog_we=1 and prog_rdy=0, every prog output is stable.
- Simultaneous push and pop on a full FIFO: both succeed and no overflow is flagged.

## Timing
- Latency: ioctl_wr sampled at edge k, into an empty FIFO with the output idle, gives prog_we high after edge k+1.
- Throughput: one write per cycle while prog_rdy is held high.
- dwnld_done rises no earlier than the edge after the final accepted prog_we&prog_rdy.
- Overflow is visible after the edge that drops the byte.

## Configuration
- JTFRAME_DWNLD_SWAP_EN
  - Defined: the lane assignment is inverted (b[0]=0 gives mask 2'b01, b[0]=1 gives mask 2'b10), for big-endian CPU ROMs. prog_addr is unchanged.
  - Undefined: the little-endian lane assignment described in Operation applies.

## Test plan
- Header skip. HEADER=2. Bytes 0..3 = 11,22,33,44 with prog_rdy=1 → exactly 2 writes: addr 0 mask 10 data 3333, then addr 0 mask 01 data 4444.
- Regions. REGIONS=2, START={0,'h100}, OFFSET={'h1000,'h8000}. Byte 'hFF → word 'h87F mask 01 region 0. Byte 'h100 → word 'h4000 mask 10 region 1.
- Back-pressure. DEPTH=4, prog_rdy=0, 6 back-to-back bytes → overflow=1, outputs frozen. Then prog_rdy=1 → exactly 5 writes, in order.
- Flush and done. downloading falls with 3 bytes pending and prog_rdy toggling 1-0 → dwnld_done pulses once, one cycle after the 3rd accept.
- Async reset mid-download. rst_n low asynchronously while prog_we=1 → all outputs 0 immediately. After release, the FIFO is empty and the state is IDLE.
- Swap. Same stimulus as the header-skip test with JTFRAME_DWNLD_SWAP_EN defined → masks 01 then 10, same addresses.

Source files
------------

// File: rtl/jtframe_dwnld_map_if.sv
// jtframe_dwnld_map_if
//
// SDRAM programming bus between the ROM-download mapper and the SDRAM
// controller's programming port. The mapper is the master: it presents one
// masked 16-bit write at a time and holds it until the controller accepts it.
//
// Parameters:
//   AW         ioctl byte-address width; prog_addr is the word address (AW-1 bits)
//
// Signals:
//   prog_addr  SDRAM word address of the pending write
//   prog_data  written byte replicated on both 8-bit lanes
//   prog_mask  active-low lane enable (bit 0 = low lane, bit 1 = high lane)
//   prog_we    write request, held until prog_rdy is seen
//   prog_rdy   controller acceptance, meaningful only while prog_we is high
//   region     mapping region the pending write belongs to
//
// Modports:
//   master     mapper side (drives the write, receives prog_rdy)
//   slave      SDRAM controller side
interface jtframe_dwnld_map_if #(
    parameter int AW = 22
);
    logic [AW-2:0] prog_addr;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          prog_rdy;
    logic [2:0]    region;

    modport master (
        output prog_addr,
        output prog_data,
        output prog_mask,
        output prog_we,
        output region,
        input  prog_rdy
    );

    modport slave (
        input  prog_addr,
        input  prog_data,
        input  prog_mask,
        input  prog_we,
        input  region,
        output prog_rdy
    );
endinterface

// File: rtl/jtframe_dwnld_map.sv
// jtframe_dwnld_map
//
// ROM-download mapper sitting between the HPS ioctl byte stream and the SDRAM
// programming port. Leading header bytes are discarded, the remaining stream
// is split into up to 8 regions, each with its own SDRAM byte destination,
// and bytes are buffered in a small FIFO so that SDRAM back-pressure does not
// lose data (the ioctl side cannot be stalled). Each byte becomes one masked
// 16-bit write which is held until the SDRAM controller accepts it.
// End-of-download is reported only once every buffered byte is committed.
//
// Parameters:
//   AW       ioctl byte-address width (prog_addr is AW-1 bits)
//   HEADER   number of leading bytes discarded
//   REGIONS  number of regions, 1..8
//   START    packed REGIONS*AW; first post-header byte of each region,
//            START[0] = 0, ascending
//   OFFSET   packed REGIONS*AW; SDRAM byte destination of each region (even)
//   DEPTH    FIFO entries, power of 2, >= 2
//
// Ports:
//   clk_sys      system clock, rising edge
//   rst_n        asynchronous active-low reset
//   downloading  download window from hps_io
//   ioctl_addr   byte address of the incoming byte
//   ioctl_data   incoming byte
//   ioctl_wr     one-cycle byte strobe
//   prog         SDRAM programming bus (jtframe_dwnld_map_if.master)
//   overflow     sticky: a byte was dropped because the FIFO was full
//   dwnld_busy   high from the downloading rise until the download is done
//   dwnld_done   one-cycle pulse once all bytes have been committed
//
// Build option:
//   JTFRAME_DWNLD_SWAP_EN  when defined, even SDRAM byte addresses go to the
//                          high lane and odd ones to the low lane (big-endian
//                          CPU ROMs). Word addresses are not affected.
module jtframe_dwnld_map #(
    parameter int                    AW      = 22,
    parameter int                    HEADER  = 0,
    parameter int                    REGIONS = 1,
    parameter logic [REGIONS*AW-1:0] START   = '0,
    parameter logic [REGIONS*AW-1:0] OFFSET  = '0,
    parameter int                    DEPTH   = 4
) (
    input  logic                       clk_sys,
    input  logic                       rst_n,
    input  logic                       downloading,
    input  logic [AW-1:0]              ioctl_addr,
    input  logic [7:0]                 ioctl_data,
    input  logic                       ioctl_wr,
    jtframe_dwnld_map_if.master        prog,
    output logic                       overflow,
    output logic                       dwnld_busy,
    output logic                       dwnld_done
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [AW-1:0] HDR     = AW'(HEADER);
    localparam logic [PW:0]   PTR_ONE = (PW+1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t        state;
    logic          dl_last;
    logic          dl_rise;

    // FIFO storage: header-relative byte address plus data
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [7:0]    fifo_data [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;

    logic          push_req;
    logic          push;
    logic          drop;
    logic          pop;

    logic [AW-1:0] head_a;
    logic [7:0]    head_d;
    logic [2:0]    map_r;
    logic [AW-1:0] map_start;
    logic [AW-1:0] map_offset;
    logic [AW-1:0] map_b;
    logic [1:0]    map_mask;

    // Pointers carry one extra wrap bit so full and empty can be told apart
    // without a separate occupancy counter.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                        (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    assign dl_rise  = downloading & ~dl_last;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still taken when the output register is draining it at the same time.
    assign push_req = ioctl_wr & downloading & (ioctl_addr >= HDR);
    assign pop      = (~prog.prog_we | prog.prog_rdy) & ~fifo_empty;
    assign push     = push_req & (~fifo_full | pop);
    assign drop     = push_req & fifo_full & ~pop;

    // FIFO data store; no reset needed since entries are only read once
    // the pointers say they were written.
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr[PW-1:0]] <= ioctl_addr - HDR;
            fifo_data[wr_ptr[PW-1:0]] <= ioctl_data;
        end
    end

    // FIFO pointers
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Region lookup on the FIFO head. START values are ascending, so the
    // last region whose start is not above the address is the one it lives in.
    always_comb begin
        head_a     = fifo_addr[rd_ptr[PW-1:0]];
        head_d     = fifo_data[rd_ptr[PW-1:0]];
        map_r      = 3'd0;
        map_start  = START[AW-1:0];
        map_offset = OFFSET[AW-1:0];
        for (int i = 0; i < REGIONS; i++) begin
            if (head_a >= START[i*AW +: AW]) begin
                map_r      = 3'(i);
                map_start  = START[i*AW +: AW];
                map_offset = OFFSET[i*AW +: AW];
            end
        end
        map_b = map_offset + (head_a - map_start);
`ifdef JTFRAME_DWNLD_SWAP_EN
        map_mask = map_b[0] ? 2'b10 : 2'b01;
`else
        map_mask = map_b[0] ? 2'b01 : 2'b10;
`endif
    end

    // Output write register: loads a new write whenever the current one is
    // absent or being accepted, and otherwise holds everything stable.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            prog.prog_addr <= '0;
            prog.prog_data <= '0;
            prog.prog_mask <= '0;
            prog.prog_we   <= 1'b0;
            prog.region    <= '0;
        end else if (pop) begin
            prog.prog_addr <= map_b[AW-1:1];
            prog.prog_data <= {head_d, head_d};
            prog.prog_mask <= map_mask;
            prog.prog_we   <= 1'b1;
            prog.region    <= map_r;
        end else if (prog.prog_we && prog.prog_rdy) begin
            prog.prog_we   <= 1'b0;
        end
    end

    // Download sequencing. FLUSH waits for the FIFO and the output register
    // to drain before announcing completion; a new download window during
    // FLUSH resumes loading without losing the buffered bytes.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dl_last    <= 1'b0;
            overflow   <= 1'b0;
            dwnld_busy <= 1'b0;
            dwnld_done <= 1'b0;
        end else begin
            dl_last    <= downloading;
            dwnld_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (dl_rise) begin
                        state      <= ST_LOAD;
                        dwnld_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (!downloading) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (dl_rise) begin
                        state <= ST_LOAD;
                    end else if (fifo_empty && !prog.prog_we) begin
                        state      <= ST_IDLE;
                        dwnld_busy <= 1'b0;
                        dwnld_done <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // a drop on the very edge that starts a new window still counts
            if (drop) begin
                overflow <= 1'b1;
            end else if (dl_rise && state != ST_LOAD) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtframe_dwnld_map.sv
// tb_jtframe_dwnld_map
//
// Bench for jtframe_dwnld_map configured with a 2-byte header, two regions
// (START 0 / 'h100, OFFSET 'h1000 / 'h8000) and a 4-entry FIFO. A queue-based
// reference model tracks the expected write stream and status outputs every
// cycle; directed scenarios add hand-computed literal expectations.
module tb_jtframe_dwnld_map;

    localparam int AW      = 22;
    localparam int HEADER  = 2;
    localparam int REGIONS = 2;
    localparam int DEPTH   = 4;
    localparam logic [REGIONS*AW-1:0] START  = {22'h100,  22'h0};
    localparam logic [REGIONS*AW-1:0] OFFSET = {22'h8000, 22'h1000};

`ifdef JTFRAME_DWNLD_SWAP_EN
    localparam logic [1:0] MASK_EVEN = 2'b01;
    localparam logic [1:0] MASK_ODD  = 2'b10;
`else
    localparam logic [1:0] MASK_EVEN = 2'b10;
    localparam logic [1:0] MASK_ODD  = 2'b01;
`endif

    typedef struct {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } byte_t;

    typedef struct {
        logic [AW-2:0] addr;
        logic [15:0]   data;
        logic [1:0]    mask;
        logic [2:0]    region;
    } wr_t;

    logic          clk_sys     = 1'b0;
    logic          rst_n       = 1'b0;
    logic          downloading = 1'b0;
    logic [AW-1:0] ioctl_addr  = '0;
    logic [7:0]    ioctl_data  = '0;
    logic          ioctl_wr    = 1'b0;
    logic          overflow;
    logic          dwnld_busy;
    logic          dwnld_done;

    jtframe_dwnld_map_if #(.AW(AW)) prog_if ();

    jtframe_dwnld_map #(
        .AW      (AW),
        .HEADER  (HEADER),
        .REGIONS (REGIONS),
        .START   (START),
        .OFFSET  (OFFSET),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog        (prog_if),
        .overflow    (overflow),
        .dwnld_busy  (dwnld_busy),
        .dwnld_done  (dwnld_done)
    );

    always #5 clk_sys = ~clk_sys;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [AW-1:0] reg_start  [REGIONS] = '{22'h0,    22'h100};
    logic [AW-1:0] reg_offset [REGIONS] = '{22'h1000, 22'h8000};

    // Reference model state
    byte_t         m_q [$];
    byte_t         m_f;
    logic          m_we     = 1'b0;
    logic [AW-2:0] m_addr   = '0;
    logic [15:0]   m_data   = '0;
    logic [1:0]    m_mask   = '0;
    logic [2:0]    m_region = '0;
    logic          m_ovf    = 1'b0;
    logic          m_busy   = 1'b0;
    logic          m_done   = 1'b0;
    logic          m_dl_prev = 1'b0;
    int            m_phase  = 0;
    logic          m_push_req;
    logic          m_was_empty;
    logic          m_pop;
    logic          m_rise;
    logic [AW-1:0] m_b;
    int            m_r;

    // Observation log
    wr_t           wlog [$];
    int            cyc           = 0;
    int            done_count    = 0;
    int            done_cycle    = 0;
    int            last_acc_cycle = 0;

    logic [7:0]    t1_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [AW-2:0] t3_words [5] = '{21'h800, 21'h800, 21'h801, 21'h801, 21'h802};

    // One comparison: count it, and report it when it differs
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Drive one ioctl byte strobe for a single cycle
    task automatic applyStimulus(input logic [AW-1:0] addr, input logic [7:0] d);
        ioctl_addr = addr;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr   = 1'b0;
    endtask

    // Wait, with a cycle budget, for the end-of-download pulse
    task automatic waitDone(input string name, input int limit);
        int n = 0;
        while (!dwnld_done && n < limit) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput(name, 32'(n < limit), 1);
        repeat (3) @(negedge clk_sys);
    endtask

    // Region / destination rule applied to a header-relative byte address
    function automatic void modelMap(input logic [AW-1:0] a, output logic [AW-1:0] b, output int r);
        r = 0;
        for (int i = 0; i < REGIONS; i++) begin
            if (a >= reg_start[i]) r = i;
        end
        b = reg_offset[r] + (a - reg_start[r]);
    endfunction

    function automatic logic [1:0] laneMask(input logic odd);
        return odd ? MASK_ODD : MASK_EVEN;
    endfunction

    // Reference model: a byte queue standing in for the FIFO, a single
    // pending-write slot, and the download window bookkeeping.
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_we = 1'b0; m_addr = '0; m_data = '0; m_mask = '0; m_region = '0;
            m_ovf = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_dl_prev = 1'b0; m_phase = 0;
        end else begin
            m_push_req  = ioctl_wr && downloading && (ioctl_addr >= AW'(HEADER));
            m_was_empty = (m_q.size() == 0);
            m_pop       = (!m_we || prog_if.prog_rdy) && !m_was_empty;
            m_rise      = downloading && !m_dl_prev;
            m_done      = 1'b0;
            if (m_phase == 0) begin
                if (m_rise) begin m_phase = 1; m_busy = 1'b1; m_ovf = 1'b0; end
            end else if (m_phase == 1) begin
                if (!downloading) m_phase = 2;
            end else begin
                if (m_rise) begin
                    m_phase = 1; m_ovf = 1'b0;
                end else if (m_was_empty && !m_we) begin
                    m_phase = 0; m_busy = 1'b0; m_done = 1'b1;
                end
            end
            if (m_pop) begin
                m_f = m_q.pop_front();
                modelMap(m_f.a, m_b, m_r);
                m_addr   = m_b[AW-1:1];
                m_data   = {m_f.d, m_f.d};
                m_mask   = laneMask(m_b[0]);
                m_region = 3'(m_r);
                m_we     = 1'b1;
            end else if (m_we && prog_if.prog_rdy) begin
                m_we = 1'b0;
            end
            if (m_push_req) begin
                if (m_q.size() < DEPTH) m_q.push_back('{a: ioctl_addr - AW'(HEADER), d: ioctl_data});
                else m_ovf = 1'b1;
            end
            m_dl_prev = downloading;
        end
    end

    // Per-cycle comparison against the model, sampled mid low phase
    always begin
        @(negedge clk_sys);
        #1;
        cyc++;
        checkOutput("prog_we", prog_if.prog_we, m_we);
        checkOutput("overflow", overflow, m_ovf);
        checkOutput("dwnld_busy", dwnld_busy, m_busy);
        checkOutput("dwnld_done", dwnld_done, m_done);
        if (m_we) begin
            checkOutput("prog_addr", prog_if.prog_addr, m_addr);
            checkOutput("prog_data", prog_if.prog_data, m_data);
            checkOutput("prog_mask", prog_if.prog_mask, m_mask);
            checkOutput("region", prog_if.region, m_region);
        end
        if (rst_n && prog_if.prog_we && prog_if.prog_rdy) begin
            wlog.push_back('{addr: prog_if.prog_addr, data: prog_if.prog_data,
                             mask: prog_if.prog_mask, region: prog_if.region});
            last_acc_cycle = cyc;
        end
        if (dwnld_done) begin
            done_count++;
            done_cycle = cyc;
        end
    end

    // Safety net against a hung run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int n;
        prog_if.prog_rdy = 1'b0;

        // Reset values
        @(negedge clk_sys);
        #2;
        checkOutput("rst_prog_we", prog_if.prog_we, 0);
        checkOutput("rst_prog_addr", prog_if.prog_addr, 0);
        checkOutput("rst_prog_mask", prog_if.prog_mask, 0);
        checkOutput("rst_overflow", overflow, 0);
        checkOutput("rst_busy", dwnld_busy, 0);
        @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);

        // Header skip: bytes 0 and 1 vanish, bytes 2 and 3 land in one word
        wlog.delete(); done_count = 0;
        prog_if.prog_rdy = 1'b1;
        downloading = 1'b1;
        @(negedge clk_sys);
        checkOutput("t1_busy_on_rise", dwnld_busy, 1);
        for (int i = 0; i < 4; i++) applyStimulus(AW'(i), t1_data[i]);
        downloading = 1'b0;
        waitDone("t1_done_timeout", 50);
        checkOutput("t1_write_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            checkOutput("t1_w0_addr", wlog[0].addr, 21'h800);
            checkOutput("t1_w0_mask", wlog[0].mask, MASK_EVEN);
            checkOutput("t1_w0_data", wlog[0].data, 16'h3333);
            checkOutput("t1_w1_addr", wlog[1].addr, 21'h800);
            checkOutput("t1_w1_mask", wlog[1].mask, MASK_ODD);
            checkOutput("t1_w1_data", wlog[1].data, 16'h4444);
        end
        checkOutput("t1_done_count", done_count, 1);
        checkOutput("t1_busy_after", dwnld_busy, 0);

        // Region boundary: last byte of region 0 and first byte of region 1
        wlog.delete(); done_count = 0;
        downloading = 1'b1;
        @(negedge clk_sys);
        applyStimulus(AW'(HEADER + 'hFF), 8'h5A);
        applyStimulus(AW'(HEADER + 'h100), 8'hA5);
        downloading = 1'b0;
        waitDone("t2_done_timeout", 50);
        checkOutput("t2_write_count", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            checkOutput("t2_w0_addr", wlog[0].addr, 21'h87F);
            checkOutput("t2_w0_mask", wlog[0].mask, MASK_ODD);
            checkOutput("t2_w0_region", wlog[0].region, 0);
            checkOutput("t2_w0_data", wlog[0].data, 16'h5A5A);
            checkOutput("t2_w1_addr", wlog[1].addr, 21'h4000);
            checkOutput("t2_w1_mask", wlog[1].mask, MASK_EVEN);
            checkOutput("t2_w1_region", wlog[1].region, 1);
        end

        // Back-pressure: six bytes against a stalled controller drop the sixth
        wlog.delete(); done_count = 0;
        prog_if.prog_rdy = 1'b0;
        downloading = 1'b1;
        @(negedge clk_sys);
        for (int i = 0; i < 6; i++) applyStimulus(AW'(HEADER + i), 8'(8'hA0 + i));
        repeat (3) @(negedge clk_sys);
        checkOutput("t3_overflow", overflow, 1);
        checkOutput("t3_we_held", prog_if.prog_we, 1);
        checkOutput("t3_addr_frozen", prog_if.prog_addr, 21'h800);
        checkOutput("t3_data_frozen", prog_if.prog_data, 16'hA0A0);
        prog_if.prog_rdy = 1'b1;
        downloading = 1'b0;
        waitDone("t3_done_timeout", 50);
        checkOutput("t3_write_count", wlog.size(), 5);
        if (wlog.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                checkOutput($sformatf("t3_w%0d_data", i), wlog[i].data, {8'(8'hA0 + i), 8'(8'hA0 + i)});
                checkOutput($sformatf("t3_w%0d_addr", i), wlog[i].addr, t3_words[i]);
            end
        end
        checkOutput("t3_overflow_sticky", overflow, 1);

        // Flush with a toggling acceptance; done must follow the last accept
        wlog.delete(); done_count = 0;
        prog_if.prog_rdy = 1'b0;
        downloading = 1'b1;
        @(negedge clk_sys);
        checkOutput("t4_overflow_cleared", overflow, 0);
        applyStimulus(AW'(HEADER + 'h10), 8'h01);
        applyStimulus(AW'(HEADER + 'h11), 8'h02);
        applyStimulus(AW'(HEADER + 'h12), 8'h03);
        downloading = 1'b0;
        prog_if.prog_rdy = 1'b1;
        n = 0;
        while (!dwnld_done && n < 60) begin
            @(negedge clk_sys);
            prog_if.prog_rdy = ~prog_if.prog_rdy;
            n++;
        end
        checkOutput("t4_done_timeout", 32'(n < 60), 1);
        prog_if.prog_rdy = 1'b0;
        repeat (3) @(negedge clk_sys);
        checkOutput("t4_write_count", wlog.size(), 3);
        checkOutput("t4_done_count", done_count, 1);
        checkOutput("t4_done_latency", done_cycle - last_acc_cycle, 2);
        if (wlog.size() >= 3) begin
            checkOutput("t4_w2_data", wlog[2].data, 16'h0303);
            checkOutput("t4_w2_addr", wlog[2].addr, 21'h809);
        end

        // Asynchronous reset while a write is pending and the FIFO holds more
        wlog.delete(); done_count = 0;
        downloading = 1'b1;
        @(negedge clk_sys);
        applyStimulus(AW'(HEADER + 4), 8'h77);
        applyStimulus(AW'(HEADER + 5), 8'h78);
        applyStimulus(AW'(HEADER + 6), 8'h79);
        n = 0;
        while (!prog_if.prog_we && n < 10) begin
            @(negedge clk_sys);
            n++;
        end
        checkOutput("t5_we_before_reset", prog_if.prog_we, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_we", prog_if.prog_we, 0);
        checkOutput("t5_rst_addr", prog_if.prog_addr, 0);
        checkOutput("t5_rst_data", prog_if.prog_data, 0);
        checkOutput("t5_rst_mask", prog_if.prog_mask, 0);
        checkOutput("t5_rst_region", prog_if.region, 0);
        checkOutput("t5_rst_busy", dwnld_busy, 0);
        downloading = 1'b0;
        repeat (2) @(negedge clk_sys);
        rst_n = 1'b1;
        @(negedge clk_sys);
        applyStimulus(AW'(HEADER + 9), 8'h99);
        repeat (2) @(negedge clk_sys);
        checkOutput("t5_idle_we", prog_if.prog_we, 0);
        checkOutput("t5_idle_busy", dwnld_busy, 0);
        wlog.delete(); done_count = 0;
        prog_if.prog_rdy = 1'b1;
        downloading = 1'b1;
        @(negedge clk_sys);
        applyStimulus(AW'(HEADER + 'h20), 8'h5C);
        downloading = 1'b0;
        waitDone("t5_done_timeout", 50);
        checkOutput("t5_write_count", wlog.size(), 1);
        if (wlog.size() >= 1) begin
            checkOutput("t5_w0_addr", wlog[0].addr, 21'h810);
            checkOutput("t5_w0_mask", wlog[0].mask, MASK_EVEN);
            checkOutput("t5_w0_data", wlog[0].data, 16'h5C5C);
        end
        checkOutput("t5_done_count", done_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
